note_tone_synth: RTL
====================

// Module: note_tone_synth
// PURPOSE
//  Consumes the 8-bit note index from the PS/2 keyboard decoder and synthesises one audio voice.
//  The voice is a square tone at the equal-tempered pitch C4..B4, shaped by an attack/sustain/release envelope.
//  Emits signed 16-bit samples at a fixed sample rate over a valid/ready handshake to the audio codec stage.
// PARAMETERS
//  SAMPLE_DIV  1042     clk cycles per sample tick (50 MHz -> ~48 kHz)
//  ENV_STEP    15'h0040 amplitude change per sample tick in ATTACK/RELEASE
//  AMP_MAX     15'h3FFF sustain amplitude; unsigned, <= 15'h7FFF
// PORTS
//  clk          in   1   system clock, 50 MHz
//  reset        in   1   synchronous, active-high
//  key_in       in   8   note index: 0..11 = C4..B4; 12 = no key; 13..255 = treated as 12
//  sample_ready in   1   codec accepts sample_data this cycle
//  sample_valid out  1   sample_data holds an unaccepted sample
//  sample_data  out  16  signed two's-complement sample
//  note_active  out  1   high when env_state != IDLE
//  env_state    out  2   0 IDLE, 1 ATTACK, 2 SUSTAIN, 3 RELEASE
//  overrun      out  1   sticky: a sample was overwritten before acceptance; cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE, amp=0, sq=1, tick/tone counters=0; all outputs 0.
//  key_in is registered once (key_q); a note is valid when key_q < 12.
//  Sample tick: tick_cnt counts 0..SAMPLE_DIV-1 continuously and wraps; tick=1 in the cycle tick_cnt==SAMPLE_DIV-1.
//  Half-period table, in clk cycles (17 bit), indexed C4..B4:
//   95556 90193 85131 80353 75843 71586 67568 63776 60196 56818 53629 50619
//  Tone: tone_cnt counts 0..half_per-1. At terminal count, sq toggles, tone_cnt <= 0, and half_per reloads from key_q.
//   This makes pitch changes phase-continuous: a new note takes effect only at the next toggle.
//  FSM (evaluated every clk; amplitude steps only on tick):
//   IDLE:    valid note -> ATTACK. In the same cycle: tone_cnt<=0, sq<=1, half_per loaded immediately.
//   ATTACK:  no note -> RELEASE (next clk).
//            On tick: amp<=min(amp+ENV_STEP,AMP_MAX); if the result == AMP_MAX -> SUSTAIN.
//   SUSTAIN: no note -> RELEASE. Note change stays in SUSTAIN (legato).
//   RELEASE: valid note -> ATTACK from the current amp, with no phase reset.
//            On tick: amp<=max(amp-ENV_STEP,0); if the result == 0 -> IDLE.
//  Arithmetic: amp is 15-bit unsigned, and add/sub saturate (compute in 16 bits, then clamp).
//   Sample value = sq ? {1'b0,amp} : -{1'b0,amp}. It is computed from the pre-update amp/sq of the tick cycle.
//  Handshake:
//   On tick, sample_data/sample_valid load in the next cycle (latency 1). The stream is continuous; IDLE yields 0.
//   sample_valid holds until sample_valid&&sample_ready, then drops the following cycle.
//   Acceptance coincident with a new load: valid stays 1 with the new data, and no overrun.
//   Load while valid&&!ready: data is overwritten with the new sample, and overrun<=1.
//   sample_data is stable whenever valid&&!ready, except on an overrun overwrite.
//  Reset mid-operation: all state returns to reset values on the next edge. No sample is flushed.
// STRUCTURE
//  piano_pkg:
//   NOTE_NONE=8'd12, NUM_NOTES=12
//   env_state_t enum (IDLE/ATTACK/SUSTAIN/RELEASE)
//   HALF_PERIOD[0:11] constant table
//  Sub-module note_period_rom: combinational key_q -> half_per lookup; 17'd0 for index >= 12, never used.
//  The top level holds the tick counter, tone counter, envelope FSM and output register.
// TESTING (sim params SAMPLE_DIV=8, ENV_STEP=15'h1000, AMP_MAX=15'h3000)
//  1. reset, key_in=12, ready=1 -> valid pulses 1 clk every 8 clks; data=0; env_state=0; note_active=0.
//  2. key_in=9 held -> ATTACK; samples 0,+0x1000,+0x2000, then SUSTAIN at amp 0x3000;
//     sq toggles every 56818 clks; data alternates +0x3000/-0x3000 (0xD000).
//  3. From SUSTAIN, key_in=12 -> RELEASE; |data| 0x3000,0x2000,0x1000, then IDLE;
//     note_active falls in the cycle amp reaches 0.
//  4. SUSTAIN on key 0, switch to key_in=11 mid half-period -> current half-period completes at 95556;
//     the next half-period is 50619; env_state stays 2.
//  5. ready=0 across 2 ticks -> overrun=1; data = 2nd sample; ready=1 -> valid drops next clk.
//     Overrun stays 1 until reset.
//  6. key_in=200 treated as no key; reset asserted mid-ATTACK -> next clk all outputs 0 and env_state IDLE.

Source files
------------

// File: rtl/piano_pkg.sv
// ---------------------------------------------------------------------------
// piano_pkg
// Shared definitions for the single-voice note synthesiser:
//   NOTE_NONE / NUM_NOTES  - note index coding (0..11 = C4..B4, 12 = no key)
//   env_state_t            - envelope state encoding, also driven on env_state
//   HALF_PERIOD            - square-wave half period per note, in clk cycles
//   amp_sat_add/amp_sat_sub- 15-bit saturating amplitude steps
// ---------------------------------------------------------------------------
package piano_pkg;

   localparam logic [7:0] NOTE_NONE = 8'd12;
   localparam int         NUM_NOTES = 12;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } env_state_t;

   // Equal-tempered C4..B4 at a 50 MHz clock, half period in clk cycles.
   localparam logic [16:0] HALF_PERIOD [0:NUM_NOTES-1] = '{
      17'd95556, 17'd90193, 17'd85131, 17'd80353, 17'd75843, 17'd71586,
      17'd67568, 17'd63776, 17'd60196, 17'd56818, 17'd53629, 17'd50619
   };

   // Rising amplitude step, clamped to the sustain level (16-bit intermediate).
   function automatic logic [14:0] amp_sat_add(input logic [14:0] amp,
                                               input logic [14:0] step,
                                               input logic [14:0] lim);
      logic [15:0] sum;
      sum = {1'b0, amp} + {1'b0, step};
      if (sum > {1'b0, lim}) begin
         return lim;
      end else begin
         return sum[14:0];
      end
   endfunction

   // Falling amplitude step, clamped at zero (borrow out of bit 15 means underflow).
   function automatic logic [14:0] amp_sat_sub(input logic [14:0] amp,
                                               input logic [14:0] step);
      logic [15:0] diff;
      diff = {1'b0, amp} - {1'b0, step};
      if (diff[15]) begin
         return 15'd0;
      end else begin
         return diff[14:0];
      end
   endfunction

endpackage

// File: rtl/note_period_rom.sv
// ---------------------------------------------------------------------------
// note_period_rom
// Combinational note index -> square-wave half period lookup.
//   key_q    in  8   registered note index
//   half_per out 17  half period in clk cycles; 0 for any index >= 12
// The zero entry is never loaded: the caller only reloads on a valid note.
// ---------------------------------------------------------------------------
module note_period_rom
   import piano_pkg::*;
(
   input  logic [7:0]  key_q,
   output logic [16:0] half_per
);

   // Table lookup, guarded so out-of-range indices never address the table.
   always_comb begin
      half_per = 17'd0;
      if (key_q < NOTE_NONE) begin
         half_per = HALF_PERIOD[key_q[3:0]];
      end else begin
         half_per = 17'd0;
      end
   end

endmodule

// File: rtl/note_tone_synth.sv
// ---------------------------------------------------------------------------
// note_tone_synth
// One square-wave voice at C4..B4 with an attack/sustain/release envelope,
// streamed as signed 16-bit samples every SAMPLE_DIV clocks.
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high
//   key_in       in   8   note index (0..11 notes, anything else = no key)
//   sample_ready in   1   downstream accepts sample_data this cycle
//   sample_valid out  1   sample_data holds an unaccepted sample
//   sample_data  out  16  signed sample
//   note_active  out  1   envelope not idle
//   env_state    out  2   0 IDLE, 1 ATTACK, 2 SUSTAIN, 3 RELEASE
//   overrun      out  1   sticky: an unaccepted sample was overwritten
// ---------------------------------------------------------------------------
module note_tone_synth
   import piano_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV = 1042,
   parameter logic [14:0] ENV_STEP   = 15'h0040,
   parameter logic [14:0] AMP_MAX    = 15'h3FFF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  key_in,
   input  logic        sample_ready,
   output logic        sample_valid,
   output logic [15:0] sample_data,
   output logic        note_active,
   output logic [1:0]  env_state,
   output logic        overrun
);

   localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);

   logic [7:0]    key_q_r;
   logic [TW-1:0] tick_cnt_r;
   logic [16:0]   tone_cnt_r;
   logic [16:0]   half_per_r;
   logic          sq_r;
   logic [14:0]   amp_r;
   env_state_t    state_r;
   logic          note_active_r;
   logic          sample_valid_r;
   logic [15:0]   sample_data_r;
   logic          overrun_r;

   logic [16:0]   rom_half_per_s;
   logic          note_valid_s;
   logic          tick_s;
   logic          tone_tc_s;
   logic [14:0]   amp_up_s;
   logic [14:0]   amp_dn_s;
   logic [15:0]   sample_nx_s;
   env_state_t    state_nx_s;
   logic [14:0]   amp_nx_s;

   note_period_rom u_rom (
      .key_q    (key_q_r),
      .half_per (rom_half_per_s)
   );

   assign note_valid_s = (key_q_r < NOTE_NONE);
   assign tick_s       = (tick_cnt_r == TICK_LAST);
   assign tone_tc_s    = (tone_cnt_r == (half_per_r - 17'd1));
   assign amp_up_s     = amp_sat_add(amp_r, ENV_STEP, AMP_MAX);
   assign amp_dn_s     = amp_sat_sub(amp_r, ENV_STEP);
   // Sample is taken from the amplitude/phase as they stand before this tick's update.
   assign sample_nx_s  = sq_r ? {1'b0, amp_r} : (16'd0 - {1'b0, amp_r});

   // Envelope next-state and amplitude; leaving ATTACK/RELEASE wins over a same-cycle step.
   always_comb begin
      state_nx_s = state_r;
      amp_nx_s   = amp_r;
      case (state_r)
         IDLE: begin
            if (note_valid_s) begin
               state_nx_s = ATTACK;
            end else begin
               state_nx_s = IDLE;
            end
         end
         ATTACK: begin
            if (!note_valid_s) begin
               state_nx_s = RELEASE;
            end else if (tick_s) begin
               amp_nx_s   = amp_up_s;
               state_nx_s = (amp_up_s == AMP_MAX) ? SUSTAIN : ATTACK;
            end else begin
               state_nx_s = ATTACK;
            end
         end
         SUSTAIN: begin
            if (!note_valid_s) begin
               state_nx_s = RELEASE;
            end else begin
               state_nx_s = SUSTAIN;
            end
         end
         RELEASE: begin
            if (note_valid_s) begin
               state_nx_s = ATTACK;
            end else if (tick_s) begin
               amp_nx_s   = amp_dn_s;
               state_nx_s = (amp_dn_s == 15'd0) ? IDLE : RELEASE;
            end else begin
               state_nx_s = RELEASE;
            end
         end
         default: begin
            state_nx_s = IDLE;
            amp_nx_s   = 15'd0;
         end
      endcase
   end

   // Key register, free-running sample tick counter and envelope registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_q_r       <= NOTE_NONE;
         tick_cnt_r    <= '0;
         state_r       <= IDLE;
         amp_r         <= 15'd0;
         note_active_r <= 1'b0;
      end else begin
         key_q_r       <= key_in;
         tick_cnt_r    <= tick_s ? '0 : (tick_cnt_r + TW'(1));
         state_r       <= state_nx_s;
         amp_r         <= amp_nx_s;
         note_active_r <= (state_nx_s != IDLE);
      end
   end

   // Tone generator: a new pitch only takes effect at the next toggle, keeping phase continuous.
   always_ff @(posedge clk) begin
      if (reset) begin
         tone_cnt_r <= 17'd0;
         half_per_r <= 17'd0;
         sq_r       <= 1'b1;
      end else if (state_r == IDLE) begin
         if (note_valid_s) begin
            tone_cnt_r <= 17'd0;
            half_per_r <= rom_half_per_s;
            sq_r       <= 1'b1;
         end
      end else if (tone_tc_s) begin
         tone_cnt_r <= 17'd0;
         sq_r       <= ~sq_r;
         // Keep the last pitch while no key is held so the period never becomes zero.
         if (note_valid_s) begin
            half_per_r <= rom_half_per_s;
         end
      end else begin
         tone_cnt_r <= tone_cnt_r + 17'd1;
      end
   end

   // Output holding register with valid/ready handshake and sticky overrun flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_valid_r <= 1'b0;
         sample_data_r  <= 16'd0;
         overrun_r      <= 1'b0;
      end else if (tick_s) begin
         sample_valid_r <= 1'b1;
         sample_data_r  <= sample_nx_s;
         if (sample_valid_r && !sample_ready) begin
            overrun_r <= 1'b1;
         end
      end else if (sample_valid_r && sample_ready) begin
         sample_valid_r <= 1'b0;
      end
   end

   assign sample_valid = sample_valid_r;
   assign sample_data  = sample_data_r;
   assign note_active  = note_active_r;
   assign env_state    = state_r;
   assign overrun      = overrun_r;

endmodule
